// File: rtl/clk_gen.sv
// ---------------------------------------------------------------------------
// clk_gen
//   Parameterised clock divider / periodic enable generator. Divides clkin
//   down to a 50% duty square wave at CLK_FREQ Hz. For example, the default
//   system clock with CLK_FREQ = 2 gives the cursor blink enable.
//   clkout is a registered level, not a clock-tree clock. Consumers should
//   sample it synchronously or use it as an enable.
//
// Parameters
//   CLK_FREQ    target output frequency in Hz
//   SYS_CLK_HZ  frequency of clkin in Hz
//   CNT_W       width of the half-period counter (must hold HALF)
//
// Ports
//   clkin   in   system clock, all state updates on its rising edge
//   rst     in   asynchronous active-low reset
//   clken   in   count enable; counter and clkout hold while low
//   clkout  out  divided square wave, registered
// ---------------------------------------------------------------------------
module clk_gen #(
    parameter int CLK_FREQ   = 1000,
    parameter int SYS_CLK_HZ = 50000000,
    parameter int CNT_W      = 32
) (
    input  logic clkin,
    input  logic rst,
    input  logic clken,
    output logic clkout
);

    // Half period in enabled clkin cycles. The division truncates.
    // A request faster than clkin/2 is clamped to toggling on every edge.
    localparam int HALF_RAW = SYS_CLK_HZ / (2 * CLK_FREQ);
    localparam int HALF_INT = (HALF_RAW == 0) ? 1 : HALF_RAW;

    localparam logic [CNT_W-1:0] HALF    = CNT_W'(HALF_INT);
    localparam logic [CNT_W-1:0] HALF_M1 = HALF - CNT_W'(1);

    logic [CNT_W-1:0] count;

    // The terminal count is HALF-1, so count never exceeds it.
    // A pause on clken simply freezes the phase of the current half period.
    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            clkout <= 1'b0;
        end else if (clken) begin
            if (count == HALF_M1) begin
                count  <= '0;
                clkout <= ~clkout;
            end else begin
                count  <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_clk_gen.sv
// ---------------------------------------------------------------------------
// tb_clk_gen
//   Directed bench for clk_gen. The stimulus process pushes the expected
//   values into a queue after each step. The monitor process pops each entry
//   and compares it against the selected instance.
//   Instances:
//     u5   : SYS_CLK_HZ=100, CLK_FREQ=10   -> HALF=5
//     u1   : SYS_CLK_HZ=100, CLK_FREQ=50   -> HALF=1
//     u0   : SYS_CLK_HZ=100, CLK_FREQ=1000 -> computes 0, clamped to 1
//     u25  : SYS_CLK_HZ=100, CLK_FREQ=2    -> HALF=25
//            (a scaled-down version of the default-clock blink case)
//     udef : SYS_CLK_HZ default, CLK_FREQ=2 -> HALF=12500000
// ---------------------------------------------------------------------------
module tb_clk_gen;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic clken = 1'b0;
    logic out5, out1, out0, out25, outd;

    always #5 clk = ~clk;

    clk_gen #(.CLK_FREQ(10),   .SYS_CLK_HZ(100), .CNT_W(32)) u5
        (.clkin(clk), .rst(rst), .clken(clken), .clkout(out5));
    clk_gen #(.CLK_FREQ(50),   .SYS_CLK_HZ(100), .CNT_W(32)) u1
        (.clkin(clk), .rst(rst), .clken(clken), .clkout(out1));
    clk_gen #(.CLK_FREQ(1000), .SYS_CLK_HZ(100), .CNT_W(32)) u0
        (.clkin(clk), .rst(rst), .clken(clken), .clkout(out0));
    clk_gen #(.CLK_FREQ(2),    .SYS_CLK_HZ(100), .CNT_W(32)) u25
        (.clkin(clk), .rst(rst), .clken(clken), .clkout(out25));
    clk_gen #(.CLK_FREQ(2)) udef
        (.clkin(clk), .rst(rst), .clken(clken), .clkout(outd));

    typedef struct {
        string tag;
        int    sel;      // 0:u5 1:u1 2:u0 3:u25
        bit    out;
        int    cnt;
        bit    chk_cnt;  // count is checked on u5 only
    } exp_t;

    exp_t q[$];
    int   n_run  = 0;
    int   n_fail = 0;
    event chk_ev;

    task automatic push(input string tag, input int sel, input bit o,
                        input int c, input bit cc);
        exp_t e;
        e.tag = tag; e.sel = sel; e.out = o; e.cnt = c; e.chk_cnt = cc;
        q.push_back(e);
    endtask

    // Sample 1 ns after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: drains the queue whenever the stimulus signals a sample point.
    initial begin : monitor
        exp_t e;
        logic a;
        forever begin
            @(chk_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                case (e.sel)
                    0:       a = out5;
                    1:       a = out1;
                    2:       a = out0;
                    default: a = out25;
                endcase
                n_run++;
                if (a !== e.out) begin
                    n_fail++;
                    $display("FAIL %s: clkout=%0b expected %0b (t=%0t)",
                             e.tag, a, e.out, $time);
                end
                if (e.chk_cnt) begin
                    n_run++;
                    if (int'(u5.count) !== e.cnt) begin
                        n_fail++;
                        $display("FAIL %s_count: count=%0d expected %0d (t=%0t)",
                                 e.tag, u5.count, e.cnt, $time);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Hand-computed expected waveforms.
    // t1: u5 clkout after edges 1..20 (rises at 5, falls at 10).
    string t1_out = "00001111100000111110";
    // t2: clken is low for edges 3..5; first rise is pushed to edge 8.
    int t2_en  [9] = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
    int t2_out [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
    int t2_cnt [9] = '{1, 2, 2, 2, 2, 3, 4, 0, 1};
    int t2_o1  [9] = '{1, 0, 0, 0, 0, 1, 0, 1, 0};
    // t5: u25 sample points (edge, level).
    int t5_edge[5] = '{24, 25, 49, 50, 75};
    int t5_out [5] = '{0, 1, 1, 0, 1};

    initial begin : stim
        rst   = 1'b0;
        clken = 1'b1;

        // Elaborated half period at the default system clock.
        n_run++;
        if (udef.HALF !== 32'd12500000) begin
            n_fail++;
            $display("FAIL default_half: HALF=%0d expected 12500000", udef.HALF);
        end

        // Reset state.
        tick(); tick();
        push("reset_u5", 0, 1'b0, 0, 1'b1);
        push("reset_u1", 1, 1'b0, 0, 1'b0);
        push("reset_u0", 2, 1'b0, 0, 1'b0);
        push("reset_u25", 3, 1'b0, 0, 1'b0);
        ->chk_ev;

        // t1/t4/t5: free-running divide after release. The next edge is edge 1.
        rst = 1'b1;
        for (int e = 1; e <= 80; e++) begin
            tick();
            if (e <= 20)
                push("t1_half5", 0, (t1_out[e-1] == "1"), e % 5, 1'b1);
            if (e <= 10) begin
                push("t4_half1", 1, e[0], 0, 1'b0);
                push("t4_clamp", 2, e[0], 0, 1'b0);
            end
            for (int k = 0; k < 5; k++)
                if (t5_edge[k] == e)
                    push("t5_half25", 3, t5_out[k][0], 0, 1'b0);
            ->chk_ev;
        end

        // t2: a clken pause stretches the half period.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int e = 0; e < 9; e++) begin
            clken = t2_en[e][0];
            tick();
            push("t2_pause", 0, t2_out[e][0], t2_cnt[e], 1'b1);
            push("t2_pause_h1", 1, t2_o1[e][0], 0, 1'b0);
            ->chk_ev;
        end

        // t3: asynchronous reset mid-period, with no clock edge involved.
        clken = 1'b1;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int e = 1; e <= 8; e++) tick();
        push("t3_pre", 0, 1'b1, 3, 1'b1);
        ->chk_ev;
        #2 rst = 1'b0;
        #1;
        push("t3_async", 0, 1'b0, 0, 1'b1);
        push("t3_async_h1", 1, 1'b0, 0, 1'b0);
        ->chk_ev;
        tick();
        push("t3_held", 0, 1'b0, 0, 1'b1);
        ->chk_ev;
        rst = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            push("t3_restart", 0, (e == 5), e % 5, 1'b1);
            ->chk_ev;
        end

        // t6: reset held low for 20 enabled edges.
        rst = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            push("t6_hold", 0, 1'b0, 0, 1'b1);
            push("t6_hold_h1", 1, 1'b0, 0, 1'b0);
            ->chk_ev;
        end
        rst = 1'b1;

        #2;
        n_run++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
